// File: rtl/fft_pkg.sv
// Shared types and index helpers for the radix-4 FFT input path.
package fft_pkg;

    localparam int CPLX_W = 16;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    // Number of base-4 digits needed to index n points (n a power of 4).
    function automatic int clog4(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++) begin
            if ((1 << (2 * i)) < n) r = i + 1;
        end
        return r;
    endfunction

    // Reverse the order of the low log4n base-4 digits of idx.
    function automatic int digitrev(input int idx, input int log4n);
        int r;
        int v;
        r = 0;
        v = idx;
        for (int i = 0; i < 16; i++) begin
            if (i < log4n) begin
                r = (r << 2) | (v & 3);
                v = v >> 2;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_r4_pingpong_inbuf_if.sv
// Sample-in / sample-out stream bundle of the ping-pong input buffer.
interface fft_r4_pingpong_inbuf_if #(
    parameter int WIDTH = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_re;
    logic signed [WIDTH-1:0] in_im;
    logic                    in_last;
    logic                    reorder_en;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_re;
    logic signed [WIDTH-1:0] out_im;
    logic                    out_first;
    logic                    out_last;
    logic                    frame_err;

    modport slave (
        input  in_valid, in_re, in_im, in_last, reorder_en, out_ready,
        output in_ready, out_valid, out_re, out_im, out_first, out_last, frame_err
    );

    modport master (
        output in_valid, in_re, in_im, in_last, reorder_en, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_first, out_last, frame_err
    );
endinterface

// File: rtl/fft_digit_rev.sv
// Combinational base-4 digit-reversal of a read index.
module fft_digit_rev
    import fft_pkg::*;
#(
    parameter int LOG4N = 2
) (
    input  logic [2*LOG4N-1:0] idx,
    output logic [2*LOG4N-1:0] rev
);
    localparam int AW = 2 * LOG4N;

    assign rev = AW'(digitrev(int'(idx), LOG4N));
endmodule

// File: rtl/fft_r4_pingpong_inbuf.sv
// Two-bank complex frame buffer: one bank fills in natural order while the
// other drains in natural or base-4 digit-reversed order.
module fft_r4_pingpong_inbuf
    import fft_pkg::*;
#(
    parameter int N     = 16,
    parameter int WIDTH = 16,
    parameter int LOG4N = clog4(N)
) (
    input logic                    clk,
    input logic                    rst_n,
    fft_r4_pingpong_inbuf_if.slave bus
);
    localparam int            AW   = 2 * LOG4N;
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    if (N < 4 || (1 << AW) != N) begin : g_bad_n
        $error("fft_r4_pingpong_inbuf: N=%0d is not a power of 4", N);
    end

    typedef struct packed {
        logic signed [WIDTH-1:0] re;
        logic signed [WIDTH-1:0] im;
    } sample_t;

    sample_t       bank [2][N];
    logic [1:0]    full;
    logic [1:0]    mode;
    logic          wr_sel;
    logic          rd_sel;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_cnt;
    logic [AW-1:0] rev_cnt;
    logic [AW-1:0] rd_addr;
    sample_t       out_data;
    logic          out_valid;
    logic          out_first;
    logic          out_last;
    logic          frame_err;

    logic accept, wr_end, wr_abort, wr_store, rd_load, rd_end;

    assign bus.in_ready = rst_n & ~full[wr_sel];
    assign accept       = bus.in_valid & bus.in_ready;
    assign wr_end       = accept & (wr_cnt == LAST);
    // An early in_last drops that sample and abandons the partial frame.
    assign wr_abort     = accept & bus.in_last & (wr_cnt != LAST);
    assign wr_store     = accept & ~wr_abort;

    assign rd_load = full[rd_sel] & (~out_valid | bus.out_ready);
    assign rd_end  = rd_load & (rd_cnt == LAST);

    fft_digit_rev #(.LOG4N(LOG4N)) u_digit_rev (
        .idx (rd_cnt),
        .rev (rev_cnt)
    );

    assign rd_addr = mode[rd_sel] ? rev_cnt : rd_cnt;

    // NOTE: sample storage has no reset; whether a bank holds a frame is tracked only by full[].
    always_ff @(posedge clk) begin
        if (wr_store) bank[wr_sel][wr_cnt] <= '{re: bus.in_re, im: bus.in_im};
    end

    // NOTE: all state below uses non-blocking assignments so every process sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel    <= 1'b0;
            wr_cnt    <= '0;
            mode      <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= accept & (bus.in_last ^ (wr_cnt == LAST));
            if (accept && wr_cnt == '0) mode[wr_sel] <= bus.reorder_en;
            if (wr_end || wr_abort)     wr_cnt <= '0;
            else if (accept)            wr_cnt <= wr_cnt + 1'b1;
            if (wr_end)                 wr_sel <= ~wr_sel;
        end
    end

    // Writer sets and reader clears full[] here; they never target the same bank in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= '0;
            rd_sel    <= 1'b0;
            rd_cnt    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            full <= (full | (wr_end ? (2'b01 << wr_sel) : 2'b00))
                  & ~(rd_end ? (2'b01 << rd_sel) : 2'b00);
            if (rd_load) begin
                out_data  <= bank[rd_sel][rd_addr];
                out_valid <= 1'b1;
                out_first <= (rd_cnt == '0);
                out_last  <= (rd_cnt == LAST);
                rd_cnt    <= rd_end ? '0 : rd_cnt + 1'b1;
                if (rd_end) rd_sel <= ~rd_sel;
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
                out_first <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_re    = out_data.re;
    assign bus.out_im    = out_data.im;
    assign bus.out_first = out_first;
    assign bus.out_last  = out_last;
    assign bus.frame_err = frame_err;
endmodule

// File: tb/tb_fft_r4_pingpong_inbuf.sv
// Directed bench for the ping-pong input buffer at N=16 plus an N=64 instance.
module tb_fft_r4_pingpong_inbuf;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_r4_pingpong_inbuf_if #(.WIDTH(16)) b16 ();
    fft_r4_pingpong_inbuf_if #(.WIDTH(16)) b64 ();

    fft_r4_pingpong_inbuf #(.N(16), .WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    fft_r4_pingpong_inbuf #(.N(64), .WIDTH(16)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    typedef struct {
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic               first;
        logic               last;
        int                 cyc;
    } obs_t;

    obs_t q16[$];
    obs_t q64[$];
    obs_t mon16, mon64;
    int   vectors = 0;
    int   miscompares = 0;
    int   ferr16 = 0;
    int   acc16 = 0;
    int   stalls16 = 0;
    int   last_acc16 = 0;
    int   last_acc64 = 0;

    // Outputs are sampled on the falling edge; a sample counts as consumed when valid & ready.
    always @(negedge clk) begin
        if (b16.out_valid && b16.out_ready) begin
            mon16.re = b16.out_re; mon16.im = b16.out_im;
            mon16.first = b16.out_first; mon16.last = b16.out_last; mon16.cyc = cyc;
            q16.push_back(mon16);
        end
        if (b64.out_valid && b64.out_ready) begin
            mon64.re = b64.out_re; mon64.im = b64.out_im;
            mon64.first = b64.out_first; mon64.last = b64.out_last; mon64.cyc = cyc;
            q64.push_back(mon64);
        end
        if (b16.frame_err) ferr16++;
    end

    function automatic int pos2idx(input int p, input int n, input bit reo);
        if (!reo) return p;
        if (n == 16) return 4 * (p % 4) + p / 4;
        return 16 * (p % 4) + 4 * ((p / 4) % 4) + p / 16;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send len samples base+i; in_last is raised on sample last_idx (-1 = never).
    task automatic send16(input int base, input int len, input int last_idx, input bit reo, input bit im_zero);
        int t;
        for (int i = 0; i < len; i++) begin
            b16.in_valid   = 1'b1;
            b16.in_re      = 16'(base + i);
            b16.in_im      = im_zero ? 16'sd0 : 16'(-(base + i));
            b16.in_last    = (i == last_idx);
            b16.reorder_en = reo;
            t = 0;
            while (!b16.in_ready && t < 300) begin step(); t++; end
            stalls16 += t;
            step();
            acc16++;
            last_acc16 = cyc;
        end
        b16.in_valid = 1'b0;
        b16.in_last  = 1'b0;
    endtask

    task automatic wait16(input int n);
        int t;
        t = 0;
        while (q16.size() < n && t < 400) begin step(); t++; end
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (b16.in_ready !== 1'b0 || b64.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b/%b want 0/0", b16.in_ready, b64.in_ready);
        end
        vectors++;
        if (b16.out_valid !== 1'b0 || b16.out_first !== 1'b0 || b16.out_last !== 1'b0 || b16.frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got v%b f%b l%b e%b want all 0",
                     b16.out_valid, b16.out_first, b16.out_last, b16.frame_err);
        end
        vectors++;
        if (b16.out_re !== 16'sd0 || b16.out_im !== 16'sd0) begin
            miscompares++;
            $display("FAIL reset_data: got re=%0d im=%0d want 0/0", b16.out_re, b16.out_im);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        vectors++;
        if (b16.in_ready !== 1'b1 || b64.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release_in_ready: got %b/%b want 1/1", b16.in_ready, b64.in_ready);
        end
    endtask

    task automatic test_reorder();
        logic signed [15:0] exp_re;
        q16.delete();
        b16.out_ready = 1'b1;
        send16(0, 16, 15, 1'b1, 1'b1);
        wait16(16);
        vectors++;
        if (q16.size() != 16) begin
            miscompares++;
            $display("FAIL reorder_count: got %0d want 16", q16.size());
        end
        for (int p = 0; p < 16 && p < q16.size(); p++) begin
            exp_re = 16'(pos2idx(p, 16, 1'b1));
            vectors++;
            if (q16[p].re !== exp_re || q16[p].im !== 16'sd0 || q16[p].first !== (p == 0) || q16[p].last !== (p == 15)) begin
                miscompares++;
                $display("FAIL reorder_pos%0d: got re=%0d im=%0d f=%b l=%b want re=%0d im=0 f=%b l=%b",
                         p, q16[p].re, q16[p].im, q16[p].first, q16[p].last, exp_re, p == 0, p == 15);
            end
        end
        vectors++;
        if (q16.size() == 0 || q16[0].cyc != last_acc16 + 1) begin
            miscompares++;
            $display("FAIL reorder_latency: got cycle %0d want %0d", q16.size() ? q16[0].cyc : -1, last_acc16 + 1);
        end
    endtask

    task automatic test_mode();
        int bases[3] = '{0, 100, 200};
        bit reos[3]  = '{1'b0, 1'b1, 1'b0};
        int f, p;
        logic signed [15:0] exp_re, exp_im;
        q16.delete();
        b16.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send16(bases[i], 16, 15, reos[i], 1'b0);
        wait16(48);
        vectors++;
        if (q16.size() != 48) begin
            miscompares++;
            $display("FAIL mode_count: got %0d want 48", q16.size());
        end
        for (int k = 0; k < 48 && k < q16.size(); k++) begin
            f = k / 16;
            p = k % 16;
            exp_re = 16'(bases[f] + pos2idx(p, 16, reos[f]));
            exp_im = 16'(-(bases[f] + pos2idx(p, 16, reos[f])));
            vectors++;
            if (q16[k].re !== exp_re || q16[k].im !== exp_im || q16[k].first !== (p == 0) || q16[k].last !== (p == 15)) begin
                miscompares++;
                $display("FAIL mode_f%0d_pos%0d: got re=%0d im=%0d f=%b l=%b want re=%0d im=%0d",
                         f, p, q16[k].re, q16[k].im, q16[k].first, q16[k].last, exp_re, exp_im);
            end
        end
    endtask

    task automatic test_back_to_back();
        int f, p;
        logic signed [15:0] exp_re;
        int bad_gap;
        q16.delete();
        stalls16 = 0;
        b16.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send16(300 + 100 * i, 16, 15, i[0] == 1'b0, 1'b0);
        vectors++;
        if (stalls16 != 0) begin
            miscompares++;
            $display("FAIL b2b_in_ready: got %0d stall cycles want 0", stalls16);
        end
        wait16(64);
        vectors++;
        if (q16.size() != 64) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d want 64", q16.size());
        end
        bad_gap = -1;
        for (int k = 1; k < q16.size(); k++) begin
            if (bad_gap < 0 && q16[k].cyc != q16[0].cyc + k) bad_gap = k;
        end
        vectors++;
        if (bad_gap >= 0) begin
            miscompares++;
            $display("FAIL b2b_gap: output %0d at cycle %0d want %0d", bad_gap, q16[bad_gap].cyc, q16[0].cyc + bad_gap);
        end
        for (int k = 0; k < 64 && k < q16.size(); k++) begin
            f = k / 16;
            p = k % 16;
            exp_re = 16'(300 + 100 * f + pos2idx(p, 16, f % 2 == 0));
            vectors++;
            if (q16[k].re !== exp_re || q16[k].first !== (p == 0) || q16[k].last !== (p == 15)) begin
                miscompares++;
                $display("FAIL b2b_f%0d_pos%0d: got re=%0d f=%b l=%b want re=%0d", f, p, q16[k].re, q16[k].first, q16[k].last, exp_re);
            end
        end
    endtask

    task automatic test_stall();
        logic signed [15:0] exp_re;
        q16.delete();
        acc16 = 0;
        b16.out_ready = 1'b0;
        fork
            begin
                send16(1000, 16, 15, 1'b0, 1'b0);
                send16(1100, 16, 15, 1'b0, 1'b0);
                send16(1200, 16, 15, 1'b0, 1'b0);
            end
            begin
                bit held_ok;
                held_ok = 1'b1;
                repeat (18) step();
                vectors++;
                if (b16.out_valid !== 1'b1 || b16.out_first !== 1'b1 || b16.out_re !== 16'sd1000) begin
                    miscompares++;
                    $display("FAIL stall_first: got v=%b f=%b re=%0d want v=1 f=1 re=1000", b16.out_valid, b16.out_first, b16.out_re);
                end
                repeat (22) begin
                    step();
                    if (b16.out_valid !== 1'b1 || b16.out_first !== 1'b1 || b16.out_last !== 1'b0
                        || b16.out_re !== 16'sd1000 || b16.out_im !== -16'sd1000) held_ok = 1'b0;
                end
                vectors++;
                if (!held_ok) begin
                    miscompares++;
                    $display("FAIL stall_hold: got outputs changing want held at re=1000");
                end
                vectors++;
                if (acc16 != 32 || b16.in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_full: got accepted=%0d in_ready=%b want 32/0", acc16, b16.in_ready);
                end
                b16.out_ready = 1'b1;
            end
        join
        wait16(48);
        vectors++;
        if (q16.size() != 48) begin
            miscompares++;
            $display("FAIL stall_count: got %0d want 48", q16.size());
        end
        for (int k = 0; k < 48 && k < q16.size(); k++) begin
            exp_re = 16'(1000 + 100 * (k / 16) + k % 16);
            vectors++;
            if (q16[k].re !== exp_re || q16[k].im !== -exp_re) begin
                miscompares++;
                $display("FAIL stall_pos%0d: got re=%0d im=%0d want re=%0d", k, q16[k].re, q16[k].im, exp_re);
            end
        end
    endtask

    task automatic test_framing();
        int f0;
        logic signed [15:0] exp_re;
        q16.delete();
        b16.out_ready = 1'b1;
        f0 = ferr16;
        send16(2000, 6, 5, 1'b1, 1'b0);
        repeat (20) step();
        vectors++;
        if (ferr16 - f0 != 1 || q16.size() != 0) begin
            miscompares++;
            $display("FAIL short_frame: got err_cycles=%0d outputs=%0d want 1/0", ferr16 - f0, q16.size());
        end
        send16(2100, 16, 15, 1'b1, 1'b0);
        send16(2200, 16, -1, 1'b0, 1'b0);
        wait16(32);
        vectors++;
        if (ferr16 - f0 != 2 || q16.size() != 32) begin
            miscompares++;
            $display("FAIL missing_last: got err_cycles=%0d outputs=%0d want 2/32", ferr16 - f0, q16.size());
        end
        for (int k = 0; k < 32 && k < q16.size(); k++) begin
            exp_re = (k < 16) ? 16'(2100 + pos2idx(k, 16, 1'b1)) : 16'(2200 + k - 16);
            vectors++;
            if (q16[k].re !== exp_re || q16[k].first !== (k % 16 == 0) || q16[k].last !== (k % 16 == 15)) begin
                miscompares++;
                $display("FAIL framing_pos%0d: got re=%0d f=%b l=%b want re=%0d", k, q16[k].re, q16[k].first, q16[k].last, exp_re);
            end
        end
    endtask

    task automatic test_reset_midread();
        int t;
        logic signed [15:0] exp_re;
        q16.delete();
        b16.out_ready = 1'b1;
        send16(3000, 16, 15, 1'b0, 1'b0);
        t = 0;
        while (!(b16.out_valid && b16.out_first) && t < 20) begin step(); t++; end
        repeat (6) step();
        vectors++;
        if (b16.out_valid !== 1'b1 || b16.out_re !== 16'sd3006) begin
            miscompares++;
            $display("FAIL midread_pos6: got v=%b re=%0d want v=1 re=3006", b16.out_valid, b16.out_re);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (b16.out_valid !== 1'b0 || b16.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midread_reset: got out_valid=%b in_ready=%b want 0/0", b16.out_valid, b16.in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        step();
        vectors++;
        if (b16.in_ready !== 1'b1 || b16.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midread_release: got in_ready=%b out_valid=%b want 1/0", b16.in_ready, b16.out_valid);
        end
        q16.delete();
        send16(3100, 16, 15, 1'b1, 1'b0);
        wait16(16);
        vectors++;
        if (q16.size() != 16) begin
            miscompares++;
            $display("FAIL midread_count: got %0d want 16", q16.size());
        end
        for (int p = 0; p < 16 && p < q16.size(); p++) begin
            exp_re = 16'(3100 + pos2idx(p, 16, 1'b1));
            vectors++;
            if (q16[p].re !== exp_re || q16[p].first !== (p == 0) || q16[p].last !== (p == 15)) begin
                miscompares++;
                $display("FAIL midread_pos%0d: got re=%0d f=%b want re=%0d", p, q16[p].re, q16[p].first, exp_re);
            end
        end
    endtask

    task automatic test_n64();
        int t;
        logic signed [15:0] exp_re;
        q64.delete();
        b64.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            b64.in_valid   = 1'b1;
            b64.in_re      = 16'(i);
            b64.in_im      = 16'sd0;
            b64.in_last    = (i == 63);
            b64.reorder_en = 1'b1;
            t = 0;
            while (!b64.in_ready && t < 300) begin step(); t++; end
            step();
            last_acc64 = cyc;
        end
        b64.in_valid = 1'b0;
        b64.in_last  = 1'b0;
        t = 0;
        while (q64.size() < 64 && t < 400) begin step(); t++; end
        repeat (4) step();
        vectors++;
        if (q64.size() != 64) begin
            miscompares++;
            $display("FAIL n64_count: got %0d want 64", q64.size());
        end
        for (int p = 0; p < 64 && p < q64.size(); p++) begin
            exp_re = 16'(pos2idx(p, 64, 1'b1));
            vectors++;
            if (q64[p].re !== exp_re || q64[p].im !== 16'sd0 || q64[p].first !== (p == 0) || q64[p].last !== (p == 63)) begin
                miscompares++;
                $display("FAIL n64_pos%0d: got re=%0d f=%b l=%b want re=%0d", p, q64[p].re, q64[p].first, q64[p].last, exp_re);
            end
        end
        vectors++;
        if (q64.size() == 0 || q64[0].cyc != last_acc64 + 1) begin
            miscompares++;
            $display("FAIL n64_latency: got cycle %0d want %0d", q64.size() ? q64[0].cyc : -1, last_acc64 + 1);
        end
    endtask

    initial begin
        b16.in_valid = 1'b0; b16.in_re = '0; b16.in_im = '0; b16.in_last = 1'b0;
        b16.reorder_en = 1'b0; b16.out_ready = 1'b0;
        b64.in_valid = 1'b0; b64.in_re = '0; b64.in_im = '0; b64.in_last = 1'b0;
        b64.reorder_en = 1'b0; b64.out_ready = 1'b0;
        test_reset();
        test_reorder();
        test_mode();
        test_back_to_back();
        test_stall();
        test_framing();
        test_reset_midread();
        test_n64();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
